// File: rtl/carry_look_ahead_4bit_core.sv
// carry_look_ahead_4bit_core: registered 4-bit flat carry-look-ahead adder, REG_IN adds an input stage.
// Define CLA_GROUP_PG_EN to add registered group propagate/generate outputs for cascading.
module carry_look_ahead_4bit_core #(
  parameter bit REG_IN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  input  logic       in_valid_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic [4:0] out_o,
  output logic       out_valid_o
`ifdef CLA_GROUP_PG_EN
  ,
  output logic       grp_p_o,
  output logic       grp_g_o
`endif
);
  logic [3:0] a_s, b_s;
  logic       cin_s, vld_s;
  generate
    if (REG_IN) begin : g_in_reg
      logic [3:0] a_q, b_q;
      logic       cin_q, vld_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          cin_q <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          a_q   <= a_i;
          b_q   <= b_i;
          cin_q <= cin_i;
          vld_q <= in_valid_i;
        end
      end
      assign a_s   = a_q;
      assign b_s   = b_q;
      assign cin_s = cin_q;
      assign vld_s = vld_q;
    end else begin : g_in_comb
      assign a_s   = a_i;
      assign b_s   = b_i;
      assign cin_s = cin_i;
      assign vld_s = in_valid_i;
    end
  endgenerate
  logic [3:0] g, p;
  logic [4:0] c;
  // Two-level sum-of-products carries: no carry depends on another carry.
  always_comb begin
    g    = a_s & b_s;
    p    = a_s ^ b_s;
    c[0] = cin_s;
    c[1] = g[0] | (p[0] & cin_s);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_s);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_s);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin_s);
  end
  logic [3:0] sum_q, sum_d;
  logic       cout_q, cout_d, vld_q;
  assign sum_d  = vld_s ? (p ^ c[3:0]) : sum_q;
  assign cout_d = vld_s ? c[4] : cout_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_s;
    end
  end
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign out_o       = {cout_q, sum_q};
  assign out_valid_o = vld_q;
`ifdef CLA_GROUP_PG_EN
  logic grp_p_q, grp_p_d, grp_g_q, grp_g_d;
  assign grp_p_d = vld_s ? (&p) : grp_p_q;
  assign grp_g_d = vld_s ? (g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])) : grp_g_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_p_q <= 1'b0;
      grp_g_q <= 1'b0;
    end else begin
      grp_p_q <= grp_p_d;
      grp_g_q <= grp_g_d;
    end
  end
  assign grp_p_o = grp_p_q;
  assign grp_g_o = grp_g_q;
`endif
endmodule

// File: tb/tb_carry_look_ahead_4bit_core.sv
// tb_carry_look_ahead_4bit_core: drives both REG_IN builds side by side and checks them against an arithmetic history model.
module tb_carry_look_ahead_4bit_core;
  logic       clk, rst_n, cin_i, in_valid_i;
  logic [3:0] a_i, b_i, s0, s1;
  logic       c0, c1, v0, v1;
  logic [4:0] o0, o1;
  int         n_cmp = 0, n_bad = 0;
  bit         qv[$];
  logic [4:0] qs[$];
  logic [4:0] eo[2];
  logic       ev[2];
`ifdef CLA_GROUP_PG_EN
  logic       gp0, gg0, gp1, gg1;
  logic       qgp[$], qgg[$];
  logic       egp[2], egg[2];
`endif

  carry_look_ahead_4bit_core #(.REG_IN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .in_valid_i(in_valid_i),
    .sum_o(s0), .cout_o(c0), .out_o(o0), .out_valid_o(v0)
`ifdef CLA_GROUP_PG_EN
    , .grp_p_o(gp0), .grp_g_o(gg0)
`endif
  );
  carry_look_ahead_4bit_core #(.REG_IN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .in_valid_i(in_valid_i),
    .sum_o(s1), .cout_o(c1), .out_o(o1), .out_valid_o(v1)
`ifdef CLA_GROUP_PG_EN
    , .grp_p_o(gp1), .grp_g_o(gg1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    qv.delete();
    qs.delete();
    for (int l = 0; l < 2; l++) begin
      eo[l] = '0;
      ev[l] = 1'b0;
    end
`ifdef CLA_GROUP_PG_EN
    qgp.delete();
    qgg.delete();
    for (int l = 0; l < 2; l++) begin
      egp[l] = 1'b0;
      egg[l] = 1'b0;
    end
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out0"}, {3'b0, o0}, 8'd0);
    chk({tag, "_vld0"}, {7'b0, v0}, 8'd0);
    chk({tag, "_out1"}, {3'b0, o1}, 8'd0);
    chk({tag, "_vld1"}, {7'b0, v1}, 8'd0);
    chk({tag, "_sum0"}, {4'b0, s0}, 8'd0);
    chk({tag, "_cout1"}, {7'b0, c1}, 8'd0);
`ifdef CLA_GROUP_PG_EN
    chk({tag, "_grp"}, {4'b0, gp0, gg0, gp1, gg1}, 8'd0);
`endif
  endtask

  // One clock: apply inputs, then after the edge compare each build with the result
  // of the input accepted 'latency' cycles ago (held value if that slot was invalid).
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
    a_i = a; b_i = b; cin_i = ci; in_valid_i = v;
    @(posedge clk);
    #1;
    qv.push_back(v);
    qs.push_back(5'(int'(a) + int'(b) + int'(ci)));
`ifdef CLA_GROUP_PG_EN
    qgp.push_back((a ^ b) == 4'hF);
    qgg.push_back((int'(a) + int'(b)) > 15);
`endif
    for (int l = 0; l < 2; l++) begin
      int idx = qv.size() - 1 - l;
      ev[l] = (idx >= 0) ? qv[idx] : 1'b0;
      if (idx >= 0 && qv[idx]) begin
        eo[l] = qs[idx];
`ifdef CLA_GROUP_PG_EN
        egp[l] = qgp[idx];
        egg[l] = qgg[idx];
`endif
      end
    end
    chk("out_l1", {3'b0, o0}, {3'b0, eo[0]});
    chk("sum_l1", {4'b0, s0}, {4'b0, eo[0][3:0]});
    chk("cout_l1", {7'b0, c0}, {7'b0, eo[0][4]});
    chk("vld_l1", {7'b0, v0}, {7'b0, ev[0]});
    chk("out_l2", {3'b0, o1}, {3'b0, eo[1]});
    chk("sum_l2", {4'b0, s1}, {4'b0, eo[1][3:0]});
    chk("cout_l2", {7'b0, c1}, {7'b0, eo[1][4]});
    chk("vld_l2", {7'b0, v1}, {7'b0, ev[1]});
`ifdef CLA_GROUP_PG_EN
    chk("grp_l1", {6'b0, gp0, gg0}, {6'b0, egp[0], egg[0]});
    chk("grp_l2", {6'b0, gp1, gg1}, {6'b0, egp[1], egg[1]});
`endif
  endtask

  initial begin
    rst_n = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; in_valid_i = 1'b0;
    clear_model();
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    step(4'd0, 4'd0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 1'b1, 1'b1);
    step(4'd14, 4'd1, 1'b1, 1'b1);
    step(4'd5, 4'd7, 1'b0, 1'b1);
    step(4'd9, 4'd9, 1'b1, 1'b1);
    step(4'd3, 4'd3, 1'b0, 1'b0);
    step(4'd6, 4'd2, 1'b1, 1'b0);
    step(4'd15, 4'd15, 1'b1, 1'b1);
    step(4'd1, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      logic [8:0] k = 9'(i);
      step(k[3:0], k[7:4], k[8], 1'b1);
    end
    for (int i = 0; i < 200; i++)
      step(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    // Asynchronous reset mid-stream with in_valid high, spanning one clock edge.
    a_i = 4'd15; b_i = 4'd15; cin_i = 1'b1; in_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    clear_model();
    #7;
    chk_zero("rst_hold");
    #3;
    rst_n = 1'b1;
    step(4'd2, 4'd3, 1'b0, 1'b1);
    step(4'd8, 4'd8, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++)
      step(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
    step(4'd15, 4'd0, 1'b0, 1'b1);
    step(4'd15, 4'd0, 1'b1, 1'b1);
    step(4'd0, 4'd0, 1'b0, 1'b0);
`ifdef CLA_GROUP_PG_EN
    chk("grp_p_15_0", {7'b0, gp1}, 8'd1);
    chk("grp_g_15_0", {7'b0, gg1}, 8'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/carry_look_ahead_4bit_core.md
CARRY_LOOK_AHEAD_4BIT_CORE -- requirements
Module: carry_look_ahead_4bit

Interface
REQ-001 The block SHALL have one parameter: REG_IN, default 0, meaning when 1 an input register stage is added (latency 2), and when 0 there is no input register (latency 1).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  4  addend A, unsigned.
REQ-005 b  input  4  addend B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 in_valid  input  1  qualifies a, b and cin for the current cycle.
REQ-008 sum  output  4  registered sum bits.
REQ-009 cout  output  1  registered carry-out (c4).
REQ-010 out  output  5  registered full result, equal to {cout, sum}.
REQ-011 out_valid  output  1  high for one cycle per accepted input, aligned with sum, cout and out.

Function
REQ-012 Per bit i=0..3: generate g_i = a_i AND b_i; propagate p_i = a_i XOR b_i.
REQ-013 Carries SHALL be flat look-ahead sum-of-products in g, p and cin, with no ripple chain: c0=cin; c1=g0|p0c0; c2=g1|p1g0|p1p0c0; c3=g2|p2g1|p2p1g0|p2p1p0c0; c4=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0.
REQ-014 sum_i = p_i XOR c_i; cout = c4.
REQ-015 out SHALL equal a + b + cin as a 5-bit unsigned value, range 0..31.
REQ-016 Latency from an in_valid-qualified input to out_valid is 1 cycle when REG_IN=0 and 2 cycles when REG_IN=1.
REQ-017 When in_valid is low, sum, cout and out SHALL hold their previous values, and out_valid SHALL go low on the corresponding cycle.
REQ-018 Back-to-back in_valid SHALL give one result per cycle, fully pipelined, with no stall and no backpressure.
REQ-019 Overflow (a+b+cin > 15) SHALL set cout=1 and leave the sum wrapped modulo 16; no other flag is required.
REQ-020 out[3:0] SHALL always equal sum and out[4] SHALL always equal cout.

Reset
REQ-021 When rst_n is low, sum, cout, out, out_valid and all internal pipeline registers SHALL clear to 0 immediately, without waiting for clk.
REQ-022 Any in-flight result during reset SHALL be discarded.
REQ-023 The first valid result after reset release SHALL come from the first in_valid-qualified input sampled with rst_n high.

Configuration
REQ-024 Macro CLA_GROUP_PG_EN: when defined, the block SHALL add two outputs, grp_p (1 bit, p3&p2&p1&p0) and grp_g (1 bit, g3|p3g2|p3p2g1|p3p2p1g0), for cascading.
REQ-025 With CLA_GROUP_PG_EN defined, grp_p and grp_g SHALL be registered with the same latency and hold rules as sum, and SHALL reset to 0.
REQ-026 When CLA_GROUP_PG_EN is not defined, grp_p and grp_g SHALL be absent from the port list and all other behaviour SHALL be unchanged.

Verification
REQ-027 Case 1: a=0, b=0, cin=0, in_valid=1 -> after the latency, sum=0, cout=0, out=0, out_valid=1.
REQ-028 Case 2: a=0, b=0, cin=1 -> sum=1, cout=0, out=1.
REQ-029 Case 3: a=14, b=1, cin=1 -> sum=0, cout=1, out=16 (full carry propagation).
REQ-030 Case 4: a=5, b=7, cin=0 -> sum=12, cout=0, out=12. Then a=9, b=9, cin=1 -> sum=3, cout=1, out=19.
REQ-031 Case 5: exhaustive sweep of all 512 combinations of a, b and cin with in_valid=1 every cycle -> each out equals a+b+cin at the stated latency, and out_valid stays continuously high. Run once with REG_IN=0 and once with REG_IN=1.
REQ-032 Case 6: assert rst_n low asynchronously mid-stream with in_valid=1 -> all outputs are 0 before the next clk edge. With in_valid=0 pulses inserted -> outputs hold their values and out_valid=0. With CLA_GROUP_PG_EN defined and a=15, b=0 -> grp_p=1 and grp_g=0.
